// File: rtl/mdio_master.sv
// Clause-22 MDIO management master.
//
// On an accepted start request the master latches its configuration and serialises one
// management frame (preamble, ST/OP/PHYAD/REGAD header, turnaround, 16 data bits) onto
// MDC/MDIO. Read frames release the line from the turnaround onwards and shift the PHY's
// answer into mdio_rx_data, which is strobed by mdio_rx_vld together with mdio_done.
//
// Ports:
//   s_axi_aclk       system clock
//   s_axi_aresetn    asynchronous active-low reset
//   mdio_cfg_word_0  [7:0] mdc_div, [8] preamble_suppress
//   mdio_cfg_word_1  [4:0] reg_addr, [12:8] phy_addr, [17:16] op (01 write, 10 read)
//   mdio_tx_data     [15:0] write data
//   mdio_start       single-cycle start request
//   mdio_busy        frame in progress
//   mdio_done        one-cycle pulse at frame end
//   mdio_err         one-cycle pulse when a start with an invalid op is rejected
//   mdio_rx_data     {zeros, read data}, held until the next read completes
//   mdio_rx_vld      one-cycle pulse with updated mdio_rx_data
//   mdc              management clock, held low while idle
//   mdio_o/mdio_t    serial data out / tristate (1 = release line)
//   mdio_i           serial data in
module mdio_master #(
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned PREAMBLE_LEN   = 32
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [REG_DATA_WIDTH-1:0] mdio_cfg_word_0,
  input  logic [REG_DATA_WIDTH-1:0] mdio_cfg_word_1,
  input  logic [REG_DATA_WIDTH-1:0] mdio_tx_data,
  input  logic                      mdio_start,
  output logic                      mdio_busy,
  output logic                      mdio_done,
  output logic                      mdio_err,
  output logic [REG_DATA_WIDTH-1:0] mdio_rx_data,
  output logic                      mdio_rx_vld,
  output logic                      mdc,
  output logic                      mdio_o,
  output logic                      mdio_t,
  input  logic                      mdio_i
);

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StEnd} state_e;

  state_e      state_q;
  logic [7:0]  div_q;
  logic [7:0]  pcnt_q;
  logic [5:0]  bit_cnt_q;
  logic [1:0]  op_q;
  logic [4:0]  phy_q;
  logic [4:0]  reg_q;
  logic [15:0] tx_q;
  logic [15:0] rx_sh_q;
  logic [15:0] rx_data_q;
  logic        mdc_q, mdio_o_q, mdio_t_q;
  logic        busy_q, done_q, err_q, rx_vld_q;

  logic        is_read;
  logic        tick, rise, fall;
  logic [1:0]  start_op;
  logic        start_ok;
  logic [15:0] hdr;
  state_e      adv_state;
  logic [5:0]  adv_cnt;
  logic        drv_t, drv_o;

  assign is_read  = (op_q == 2'b10);
  assign start_op = mdio_cfg_word_1[17:16];
  assign start_ok = (start_op == 2'b01) || (start_op == 2'b10);
  // Two pad bits keep a 4-bit index in range; only [13:0] is ever addressed.
  assign hdr      = {2'b00, 2'b01, op_q, phy_q, reg_q};

  assign tick = busy_q && (pcnt_q == div_q);
  assign rise = tick && !mdc_q;
  assign fall = tick && mdc_q;

  // State and bit index that take effect on the next falling MDC edge.
  always_comb begin
    adv_state = state_q;
    adv_cnt   = bit_cnt_q - 6'd1;
    if (bit_cnt_q == 6'd0) begin
      case (state_q)
        StPre:   begin adv_state = StHdr;  adv_cnt = 6'd13; end
        StHdr:   begin adv_state = StTa;   adv_cnt = 6'd1;  end
        StTa:    begin adv_state = StData; adv_cnt = 6'd15; end
        default: begin adv_state = state_q; adv_cnt = bit_cnt_q; end
      endcase
    end
  end

  // Line value for the bit that starts at that falling edge.
  always_comb begin
    drv_t = 1'b1;
    drv_o = 1'b1;
    case (adv_state)
      StPre: begin
        drv_t = 1'b0;
        drv_o = 1'b1;
      end
      StHdr: begin
        drv_t = 1'b0;
        drv_o = hdr[adv_cnt[3:0]];
      end
      StTa: begin
        if (!is_read) begin
          drv_t = 1'b0;
          drv_o = adv_cnt[0];  // 1 then 0
        end
      end
      StData: begin
        if (!is_read) begin
          drv_t = 1'b0;
          drv_o = tx_q[adv_cnt[3:0]];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      pcnt_q    <= 8'd0;
      bit_cnt_q <= 6'd0;
      op_q      <= 2'b00;
      phy_q     <= 5'd0;
      reg_q     <= 5'd0;
      tx_q      <= 16'd0;
      rx_sh_q   <= 16'd0;
      rx_data_q <= 16'd0;
      mdc_q     <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_t_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_vld_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_vld_q <= 1'b0;
      if (state_q == StIdle) begin
        pcnt_q <= 8'd0;
        mdc_q  <= 1'b0;
        if (mdio_start) begin
          if (start_ok) begin
            div_q    <= (mdio_cfg_word_0[7:0] == 8'd0) ? 8'd1 : mdio_cfg_word_0[7:0];
            op_q     <= start_op;
            phy_q    <= mdio_cfg_word_1[12:8];
            reg_q    <= mdio_cfg_word_1[4:0];
            tx_q     <= mdio_tx_data[15:0];
            busy_q   <= 1'b1;
            mdio_t_q <= 1'b0;
            if (mdio_cfg_word_0[8]) begin
              state_q   <= StHdr;
              bit_cnt_q <= 6'd13;
              mdio_o_q  <= 1'b0;  // ST msb
            end else begin
              state_q   <= StPre;
              bit_cnt_q <= 6'(PREAMBLE_LEN - 1);
              mdio_o_q  <= 1'b1;
            end
          end else begin
            err_q <= 1'b1;
          end
        end
      end else begin
        if (tick) begin
          pcnt_q <= 8'd0;
          mdc_q  <= ~mdc_q;
        end else begin
          pcnt_q <= pcnt_q + 8'd1;
        end
        if (rise && (state_q == StData)) begin
          if (is_read) begin
            rx_sh_q <= {rx_sh_q[14:0], mdio_i};
          end
          if (bit_cnt_q == 6'd0) begin
            state_q <= StEnd;
          end
        end
        if (fall) begin
          if (state_q == StEnd) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            mdc_q    <= 1'b0;
            mdio_t_q <= 1'b1;
            mdio_o_q <= 1'b1;
            pcnt_q   <= 8'd0;
            if (is_read) begin
              rx_vld_q  <= 1'b1;
              rx_data_q <= rx_sh_q;
            end
          end else begin
            state_q   <= adv_state;
            bit_cnt_q <= adv_cnt;
            mdio_t_q  <= drv_t;
            mdio_o_q  <= drv_o;
          end
        end
      end
    end
  end

  assign mdio_busy    = busy_q;
  assign mdio_done    = done_q;
  assign mdio_err     = err_q;
  assign mdio_rx_vld  = rx_vld_q;
  assign mdio_rx_data = {{(REG_DATA_WIDTH-16){1'b0}}, rx_data_q};
  assign mdc          = mdc_q;
  assign mdio_o       = mdio_o_q;
  assign mdio_t       = mdio_t_q;

  logic unused_cfg;
  assign unused_cfg = ^{mdio_cfg_word_0[REG_DATA_WIDTH-1:9], mdio_cfg_word_1[REG_DATA_WIDTH-1:18],
                        mdio_cfg_word_1[15:13], mdio_cfg_word_1[7:5],
                        mdio_tx_data[REG_DATA_WIDTH-1:16]};

endmodule
